execute_stage: RTL

//  Execute (E) stage of the 5-stage RV32I pipeline plus the E->M pipeline register.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/execute_stage_alu.sv | 34 +++
 rtl/execute_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module : pipe_pkg
//  Brief  : Shared ALU, branch and forwarding codes for the RV32I pipeline.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef logic [2:0] alu_op_t;
    typedef logic [2:0] br_op_t;
    typedef logic [1:0] fwd_sel_t;

    localparam alu_op_t ALU_ADD  = 3'b000;
    localparam alu_op_t ALU_SUB  = 3'b001;
    localparam alu_op_t ALU_AND  = 3'b010;
    localparam alu_op_t ALU_OR   = 3'b011;
    localparam alu_op_t ALU_XOR  = 3'b100;
    localparam alu_op_t ALU_SLT  = 3'b101;
    localparam alu_op_t ALU_SLTU = 3'b110;
    localparam alu_op_t ALU_ADD2 = 3'b111;

    localparam br_op_t BR_BEQ  = 3'b000;
    localparam br_op_t BR_BNE  = 3'b001;
    localparam br_op_t BR_BLT  = 3'b100;
    localparam br_op_t BR_BGE  = 3'b101;
    localparam br_op_t BR_BLTU = 3'b110;
    localparam br_op_t BR_BGEU = 3'b111;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

`default_nettype wire

// File: rtl/execute_stage_alu.sv
// ============================================================================
//  Module : alu
//  Brief  : Combinational RV32I ALU; arithmetic wraps, slt/sltu yield 0/1.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module alu
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_t         alu_control_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (alu_control_i)
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default:  result_o = a_i + b_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
//  Module : execute_stage
//  Brief  : RV32I execute stage with operand forwarding, branch resolve and E->M register.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module execute_stage
    import pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       RD1_E,
    input  logic [XLEN-1:0]       RD2_E,
    input  logic [XLEN-1:0]       Imm_Ext_E,
    input  logic [XLEN-1:0]       PCE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [2:0]            ALUControlE,
    input  logic                  ALUSrcE,
    input  logic                  RegWriteE,
    input  logic                  MemWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  BranchE,
    input  logic                  JumpE,
    input  logic [2:0]            Funct3E,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [XLEN-1:0]       ResultW,
    input  logic                  EnM,
    input  logic                  BubbleE,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [REG_ADDR_W-1:0] RD_M,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [XLEN-1:0]       PCPlus4M,
    output logic                  ValidM
);

    logic [XLEN-1:0]       src_a, src_b_fwd, src_b, alu_result;
    logic                  br_cond;

    logic [XLEN-1:0]       alu_result_q, alu_result_d;
    logic [XLEN-1:0]       write_data_q, write_data_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_write_q, mem_write_d;
    logic [1:0]            result_src_q, result_src_d;
    logic [XLEN-1:0]       pc_plus4_q, pc_plus4_d;
    logic                  valid_q, valid_d;

    // The MEM forward path taps this stage's own output register.
    always_comb begin
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
        case (ForwardBE)
            FWD_WB:  src_b_fwd = ResultW;
            FWD_MEM: src_b_fwd = alu_result_q;
            default: src_b_fwd = RD2_E;
        endcase
        src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a_i           (src_a),
        .b_i           (src_b),
        .alu_control_i (ALUControlE),
        .result_o      (alu_result)
    );

    always_comb begin
        br_cond = 1'b0;
        case (Funct3E)
            BR_BEQ:  br_cond = (src_a == src_b_fwd);
            BR_BNE:  br_cond = (src_a != src_b_fwd);
            BR_BLT:  br_cond = ($signed(src_a) <  $signed(src_b_fwd));
            BR_BGE:  br_cond = ($signed(src_a) >= $signed(src_b_fwd));
            BR_BLTU: br_cond = (src_a <  src_b_fwd);
            BR_BGEU: br_cond = (src_a >= src_b_fwd);
            default: br_cond = 1'b0;
        endcase
    end

    assign PCSrcE    = rst & (JumpE | (BranchE & br_cond));
    assign PCTargetE = PCE + Imm_Ext_E;

    always_comb begin
        alu_result_d = '0;
        write_data_d = '0;
        rd_d         = '0;
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        result_src_d = '0;
        pc_plus4_d   = '0;
        valid_d      = 1'b0;
        if (!BubbleE) begin
            alu_result_d = alu_result;
            write_data_d = src_b_fwd;
            rd_d         = RD_E;
            reg_write_d  = RegWriteE;
            mem_write_d  = MemWriteE;
            result_src_d = ResultSrcE;
            pc_plus4_d   = PCPlus4E;
            valid_d      = 1'b1;
        end
    end

    // A stall (EnM=0) outranks a bubble; the bubble is re-presented upstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            pc_plus4_q   <= '0;
            valid_q      <= 1'b0;
        end else if (EnM) begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            pc_plus4_q   <= pc_plus4_d;
            valid_q      <= valid_d;
        end
    end

    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign RD_M       = rd_q;
    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign PCPlus4M   = pc_plus4_q;
    assign ValidM     = valid_q;

endmodule

`default_nettype wire
